ycr_dmem_router_mp: RTL and testbench

- N-port data memory router placed between the core DMEM interface and up to 8 downstream targets (TCM, timer, AXI/Wishbone bridges, ...).
- Generalised in port count, address/data width and number of in-flight requests: back-to-back requests to the same target are pipelined without waiting for responses.
- Addresses matching no window get a local RDY_ER response, so the core never hangs.
- Responses always return to the core in request order.

---
 rtl/ycr_dmem_router_mp_pkg.sv | 29 ++
 rtl/ycr_dmem_rt_tagfifo.sv | 53 +++++
 rtl/ycr_dmem_router_mp.sv | 110 +++++++++++
 tb/tb_ycr_dmem_router_mp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ycr_dmem_router_mp_pkg.sv
// ycr_dmem_router_mp_pkg: shared memory-interface encodings and tag-width helper
//   memif_resp_e  : NOTRDY / RDY_OK / RDY_ER response codes
//   memif_cmd_e   : read / write command codes
//   memif_width_e : byte / half / word access widths
//   tag_width()   : bits needed to tag N_PORTS targets plus the internal error responder
package ycr_dmem_router_mp_pkg;

    typedef enum logic [1:0] {
        MEMIF_NOTRDY = 2'd0,
        MEMIF_RDY_OK = 2'd1,
        MEMIF_RDY_ER = 2'd2
    } memif_resp_e;

    typedef enum logic {
        MEMIF_CMD_RD = 1'b0,
        MEMIF_CMD_WR = 1'b1
    } memif_cmd_e;

    typedef enum logic [1:0] {
        MEMIF_BYTE  = 2'd0,
        MEMIF_HWORD = 2'd1,
        MEMIF_WORD  = 2'd2
    } memif_width_e;

    function automatic int tag_width(input int n_ports);
        return (n_ports < 1) ? 1 : $clog2(n_ports + 1);
    endfunction

endpackage

// File: rtl/ycr_dmem_rt_tagfifo.sv
// ycr_dmem_rt_tagfifo: DEPTH x TAGW FIFO of target tags for in-flight requests
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_tag  : enqueue a tag
//   pop             : dequeue the head tag
//   head_tag        : oldest tag, last_tag : most recently pushed tag
//   cnt, full, empty: occupancy
module ycr_dmem_rt_tagfifo #(
    parameter  int DEPTH = 2,
    parameter  int TAGW  = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [TAGW-1:0] push_tag,
    output logic [TAGW-1:0] head_tag,
    output logic [TAGW-1:0] last_tag,
    output logic [CW-1:0]   cnt,
    output logic            full,
    output logic            empty
);
    logic [TAGW-1:0] mem [DEPTH];
    logic [PW-1:0]   head, tail;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            last_tag <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_tag;
                tail      <= nxt(tail);
                last_tag  <= push_tag;
            end
            if (pop) head <= nxt(head);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head_tag = mem[head];
    assign full     = cnt == CW'(DEPTH);
    assign empty    = cnt == '0;

endmodule

// File: rtl/ycr_dmem_router_mp.sv
// ycr_dmem_router_mp: N-port in-order DMEM router with pipelined same-target requests
//   clk, rst_n                 : clock, asynchronous active-low reset
//   dmem_*                     : core-side request/response interface
//   port_req, port_req_ack     : per-target request handshake
//   port_cmd/width/addr/wdata  : request fields broadcast to every target
//   port_rdata, port_resp      : per-target response, port i at slice i
module ycr_dmem_router_mp
    import ycr_dmem_router_mp_pkg::*;
#(
    parameter int                        N_PORTS       = 4,
    parameter int                        AWIDTH        = 32,
    parameter int                        DWIDTH        = 32,
    parameter int                        OUTSTD        = 2,
    parameter logic [N_PORTS*AWIDTH-1:0] ADDR_MASK     = {N_PORTS{32'hFFFF_0000}},
    parameter logic [N_PORTS*AWIDTH-1:0] ADDR_PATTERN  = {32'h0003_0000, 32'h0002_0000,
                                                          32'h0001_0000, 32'h0000_0000},
    parameter bit                        MISS_TO_PORT0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dmem_req,
    output logic                   dmem_req_ack,
    input  logic                   dmem_cmd,
    input  logic [1:0]             dmem_width,
    input  logic [AWIDTH-1:0]      dmem_addr,
    input  logic [DWIDTH-1:0]      dmem_wdata,
    output logic [DWIDTH-1:0]      dmem_rdata,
    output logic [1:0]             dmem_resp,
    output logic [N_PORTS-1:0]     port_req,
    input  logic [N_PORTS-1:0]     port_req_ack,
    output logic                   port_cmd,
    output logic [1:0]             port_width,
    output logic [AWIDTH-1:0]      port_addr,
    output logic [DWIDTH-1:0]      port_wdata,
    input  logic [N_PORTS*DWIDTH-1:0] port_rdata,
    input  logic [N_PORTS*2-1:0]   port_resp
);
    localparam int              TAGW = tag_width(N_PORTS);
    localparam int              CW   = $clog2(OUTSTD + 1);
    localparam logic [TAGW-1:0] ERR  = TAGW'(N_PORTS);

    logic [TAGW-1:0]   sel, head_tag, last_tag;
    logic [CW-1:0]     cnt;
    logic              full, empty, push, pop, head_err, room, drained, can_issue;
    logic [1:0]        p_resp;
    logic [DWIDTH-1:0] p_rdata;

    // Scanning downwards leaves the lowest matching window as the winner.
    always_comb begin
        sel = MISS_TO_PORT0 ? '0 : ERR;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if ((dmem_addr & ADDR_MASK[i*AWIDTH +: AWIDTH]) == ADDR_PATTERN[i*AWIDTH +: AWIDTH])
                sel = TAGW'(i);
    end

    always_comb begin
        p_resp  = '0;
        p_rdata = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (head_tag == TAGW'(i)) begin
                p_resp  = port_resp[i*2 +: 2];
                p_rdata = port_rdata[i*DWIDTH +: DWIDTH];
            end
    end

    // An ERR entry answers as soon as it reaches the head; the FIFO register
    // already places that at least one cycle after its push.
    assign head_err   = head_tag == ERR;
    assign pop        = !empty & (head_err | p_resp == MEMIF_RDY_OK | p_resp == MEMIF_RDY_ER);
    assign dmem_resp  = empty ? MEMIF_NOTRDY : head_err ? MEMIF_RDY_ER : p_resp;
    assign dmem_rdata = (empty | head_err) ? '0 : p_rdata;

    // Switching targets only after a full drain keeps responses in request order.
    assign room         = !full | pop;
    assign drained      = empty | (cnt == CW'(1) & pop);
    assign can_issue    = rst_n & room & (drained | sel == last_tag);
    assign port_req     = (dmem_req & can_issue & sel != ERR) ? N_PORTS'(1) << sel : '0;
    assign dmem_req_ack = (sel == ERR) ? dmem_req & can_issue : |(port_req & port_req_ack);
    assign push         = dmem_req & dmem_req_ack;

    assign port_cmd   = dmem_cmd;
    assign port_width = dmem_width;
    assign port_addr  = dmem_addr;
    assign port_wdata = dmem_wdata;

    ycr_dmem_rt_tagfifo #(.DEPTH(OUTSTD), .TAGW(TAGW)) u_tagfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_tag (sel),
        .head_tag (head_tag),
        .last_tag (last_tag),
        .cnt      (cnt),
        .full     (full),
        .empty    (empty)
    );

`ifdef YCR_TRGT_SIMULATION
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dmem_req && $isunknown({dmem_cmd, dmem_width, sel})))
                else $error("X on request fields while dmem_req is high");
            assert (cnt <= CW'(OUTSTD))
                else $error("tag FIFO count above OUTSTD");
        end
    end
`endif

endmodule

// File: tb/tb_ycr_dmem_router_mp.sv
// tb_ycr_dmem_router_mp: random-stimulus scoreboard bench for ycr_dmem_router_mp
module tb_ycr_dmem_router_mp;
    localparam int NP   = 4;
    localparam int OUT  = 2;
    localparam int ERRT = NP;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              dmem_req = 1'b0, dmem_req_ack, dmem_cmd = 1'b0;
    logic [1:0]        dmem_width = '0, dmem_resp;
    logic [31:0]       dmem_addr = '0, dmem_wdata = '0, dmem_rdata;
    logic [NP-1:0]     port_req, port_req_ack = '0;
    logic              port_cmd;
    logic [1:0]        port_width;
    logic [31:0]       port_addr, port_wdata;
    logic [NP*32-1:0]  port_rdata = '0;
    logic [NP*2-1:0]   port_resp = '0;

    always #5 clk = ~clk;

    ycr_dmem_router_mp #(
        .N_PORTS(NP), .AWIDTH(32), .DWIDTH(32), .OUTSTD(OUT),
        .ADDR_MASK({NP{32'hFFFF_0000}}),
        .ADDR_PATTERN({32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .MISS_TO_PORT0(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .port_req(port_req), .port_req_ack(port_req_ack), .port_cmd(port_cmd),
        .port_width(port_width), .port_addr(port_addr), .port_wdata(port_wdata),
        .port_rdata(port_rdata), .port_resp(port_resp)
    );

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    ent_t pend[$];
    int   total = 0, bad = 0, last_t = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        return (a[31:16] < NP) ? int'(a[31:16]) : ERRT;
    endfunction

    task automatic cycle(input int req_pct, input int rsp_pct, input int force_t);
        int            t, cnt, tgt;
        bit            pop_exp, issue, exp_ack;
        logic [NP-1:0] exp_req;
        ent_t          e;
        @(negedge clk);
        port_resp  = '0;
        port_rdata = '0;
        if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
            port_resp[pend[0].port*2 +: 2]   = pend[0].resp;
            port_rdata[pend[0].port*32 +: 32] = pend[0].data;
            void'(pend.pop_front());
        end
        t = (force_t >= 0) ? force_t : ($urandom_range(99) < 60) ? last_t : int'($urandom_range(NP));
        last_t       = t;
        dmem_req     = $urandom_range(99) < req_pct;
        dmem_addr    = (t == ERRT) ? {16'($urandom_range(16'hFFFF, NP)), 16'($urandom)}
                                   : {16'(t), 16'($urandom)};
        dmem_cmd     = 1'($urandom);
        dmem_width   = 2'($urandom_range(2));
        dmem_wdata   = $urandom;
        port_req_ack = NP'($urandom);
        #2;
        cnt     = sb.size();
        pop_exp = cnt > 0 && (sb[0].port == ERRT || port_resp[sb[0].port*2 +: 2] != 2'd0);
        tgt     = decode(dmem_addr);
        issue   = dmem_req && (cnt - int'(pop_exp)) < OUT &&
                  ((cnt - int'(pop_exp)) == 0 || (cnt > 0 && sb[cnt-1].port == tgt));
        exp_req = (issue && tgt != ERRT) ? NP'(1) << tgt : '0;
        exp_ack = issue && (tgt == ERRT || port_req_ack[tgt % NP]);
        check("port_req", port_req, exp_req);
        check("req_ack", dmem_req_ack, exp_ack);
        if (dmem_req) check("port_addr", port_addr, dmem_addr);
        if (exp_ack) begin
            e.port = tgt;
            e.resp = (tgt == ERRT) ? 2'd2 : ($urandom_range(3) == 0) ? 2'd2 : 2'd1;
            e.data = (tgt == ERRT) ? 32'd0 : $urandom;
            sb.push_back(e);
            if (tgt != ERRT) pend.push_back(e);
        end
    endtask

    initial begin
        int   wait_c = 0;
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) wait_c = 0;
            else if (dmem_resp != 2'd0) begin
                wait_c = 0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp=%0d with nothing outstanding", dmem_resp);
                end else begin
                    e = sb.pop_front();
                    check("resp", dmem_resp, e.resp);
                    check("rdata", dmem_rdata, e.data);
                end
            end else if (sb.size() > 0 && ++wait_c > 200) begin
                total++;
                bad++;
                $display("FAIL resp_timeout: got no response in %0d cycles, want one", wait_c);
                void'(sb.pop_front());
                wait_c = 0;
            end
        end
    end

    initial begin
        int n;
        dmem_req     = 1'b1;
        dmem_addr    = 32'h0001_0040;
        port_req_ack = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", dmem_req_ack, 0);
        check("reset_port_req", port_req, 0);
        check("reset_resp", dmem_resp, 0);
        check("reset_rdata", dmem_rdata, 0);
        @(negedge clk);
        dmem_req = 1'b0;
        rst_n    = 1'b1;
        repeat (400) cycle(70, 30, -1);
        repeat (400) cycle(90, 70, -1);
        n = 0;
        while (sb.size() > 0 && n < 300) begin cycle(0, 100, -1); n++; end
        n = 0;
        while (sb.size() < 2 && n < 30) begin cycle(100, 0, 1); n++; end
        check("reset_setup_outstanding", sb.size(), 2);
        @(negedge clk);
        dmem_req     = 1'b1;
        dmem_addr    = 32'h0001_0040;
        port_req_ack = '1;
        port_resp    = '0;
        rst_n        = 1'b0;
        #1;
        check("midreset_ack", dmem_req_ack, 0);
        check("midreset_port_req", port_req, 0);
        check("midreset_resp", dmem_resp, 0);
        check("midreset_rdata", dmem_rdata, 0);
        sb.delete();
        pend.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_req = 1'b0;
        cycle(100, 100, 2);
        repeat (300) cycle(60, 50, -1);
        n = 0;
        while (sb.size() > 0 && n < 300) begin cycle(0, 100, -1); n++; end
        check("drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
